// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Two requester word ports plus the shared single-ported memory port.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          read_a;
    logic          write_a;
    logic [1:0]    wmask_a;
    logic [AW-1:0] address_a;
    logic [DW-1:0] wdata_a;
    logic          resp_a;
    logic [DW-1:0] rdata_a;

    logic          read_b;
    logic          write_b;
    logic [1:0]    wmask_b;
    logic [AW-1:0] address_b;
    logic [DW-1:0] wdata_b;
    logic          resp_b;
    logic [DW-1:0] rdata_b;

    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_wmask;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_resp;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // Requesters and the memory model sit on the master side.
    modport master (
        output read_a, write_a, wmask_a, address_a, wdata_a,
        output read_b, write_b, wmask_b, address_b, wdata_b,
        output mem_resp, mem_rdata,
        input  resp_a, rdata_a, resp_b, rdata_b,
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        input  busy
    );

    modport slave (
        input  read_a, write_a, wmask_a, address_a, wdata_a,
        input  read_b, write_b, wmask_b, address_b, wdata_b,
        input  mem_resp, mem_rdata,
        output resp_a, rdata_a, resp_b, rdata_b,
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Merges fetch (A) and MEM-stage (B) word ports onto one memory,
//            B-priority with a bounded A-starvation streak.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 16,
    parameter int DW           = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam int            SW      = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_A = 2'd1,
        S_BUSY_B = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q,       state_d;
    logic [SW-1:0] streak_q,      streak_d;
    logic          mem_read_q,    mem_read_d;
    logic          mem_write_q,   mem_write_d;
    logic [1:0]    mem_wmask_q,   mem_wmask_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_wdata_q,   mem_wdata_d;
    logic          resp_a_q,      resp_a_d;
    logic          resp_b_q,      resp_b_d;
    logic [DW-1:0] rdata_a_q,     rdata_a_d;
    logic [DW-1:0] rdata_b_q,     rdata_b_d;

    logic w_req_a;
    logic w_req_b;
    logic w_force_a;
    logic w_grant_a;
    logic w_grant_b;

    assign w_req_a   = bus.read_a | bus.write_a;
    assign w_req_b   = bus.read_b | bus.write_b;
    // A wins a contested IDLE cycle only once B has taken STARVE_LIMIT grants in a row.
    assign w_force_a = (STARVE_LIMIT != 0) && (streak_q == LIMIT_C);
    assign w_grant_b = (state_q == S_IDLE) && w_req_b && !(w_req_a && w_force_a);
    assign w_grant_a = (state_q == S_IDLE) && w_req_a && !w_grant_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            streak_q      <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wmask_q   <= 2'b00;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            resp_a_q      <= 1'b0;
            resp_b_q      <= 1'b0;
            rdata_a_q     <= '0;
            rdata_b_q     <= '0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wmask_q   <= mem_wmask_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            resp_a_q      <= resp_a_d;
            resp_b_q      <= resp_b_d;
            rdata_a_q     <= rdata_a_d;
            rdata_b_q     <= rdata_b_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_wmask_d   = mem_wmask_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        resp_a_d      = 1'b0;
        resp_b_d      = 1'b0;
        rdata_a_d     = rdata_a_q;
        rdata_b_d     = rdata_b_q;

        case (state_q)
            S_IDLE: begin
                // A simultaneous read+write on one port is issued as a write.
                if (w_grant_b) begin
                    mem_write_d   = bus.write_b;
                    mem_read_d    = bus.read_b & ~bus.write_b;
                    mem_wmask_d   = bus.wmask_b;
                    mem_address_d = bus.address_b;
                    mem_wdata_d   = bus.wdata_b;
                    state_d       = S_BUSY_B;
                end else if (w_grant_a) begin
                    mem_write_d   = bus.write_a;
                    mem_read_d    = bus.read_a & ~bus.write_a;
                    mem_wmask_d   = bus.wmask_a;
                    mem_address_d = bus.address_a;
                    mem_wdata_d   = bus.wdata_a;
                    state_d       = S_BUSY_A;
                end

                if (w_grant_a) begin
                    streak_d = '0;
                end else if (w_grant_b && w_req_a) begin
                    streak_d = (streak_q == LIMIT_C) ? streak_q : streak_q + 1'b1;
                end else if (!w_req_a) begin
                    streak_d = '0;
                end
            end

            S_BUSY_A: begin
                if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    resp_a_d    = 1'b1;
                    if (mem_read_q) begin
                        rdata_a_d = bus.mem_rdata;
                    end
                    state_d     = S_DONE;
                end
            end

            S_BUSY_B: begin
                if (bus.mem_resp) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    resp_b_d    = 1'b1;
                    if (mem_read_q) begin
                        rdata_b_d = bus.mem_rdata;
                    end
                    state_d     = S_DONE;
                end
            end

            // One dead cycle so requesters can retire or change their request after resp.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_wmask   = mem_wmask_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.resp_a      = resp_a_q;
    assign bus.resp_b      = resp_b_q;
    assign bus.rdata_a     = rdata_a_q;
    assign bus.rdata_b     = rdata_b_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed scoreboard bench for mem_port_arbiter (STARVE_LIMIT = 4).
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
    } mem_exp_t;

    typedef struct {
        logic        port_b;
        logic [15:0] rdata;
    } resp_exp_t;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    mem_exp_t  exp_mem[$];
    resp_exp_t exp_resp[$];
    logic [15:0] mem_model [logic [15:0]];

    int   latency    = 1;
    logic tie_resp   = 1'b0;
    logic force_resp = 1'b0;
    logic [15:0] last_rd_a = 16'h0;
    logic [15:0] last_rd_b = 16'h0;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .AW          (16),
        .DW          (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return mem_model.exists(a) ? mem_model[a] : 16'h0000;
    endfunction

    task automatic push_mem(input logic wr, input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] m);
        mem_exp_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.mask = m;
        exp_mem.push_back(e);
    endtask

    task automatic push_resp(input logic pb, input logic [15:0] rd);
        resp_exp_t e;
        e.port_b = pb; e.rdata = rd;
        exp_resp.push_back(e);
    endtask

    task automatic wait_resp(input logic pb, input int budget, output int n);
        logic got;
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            @(posedge clk); #1;
            n++;
            got = pb ? bus.resp_b : bus.resp_a;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: no resp on port %s within %0d cycles", pb ? "B" : "A", budget);
        end
    endtask

    task automatic drive_port(input logic pb, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
        if (pb) begin
            bus.read_b = rd; bus.write_b = wr; bus.address_b = a; bus.wdata_b = d; bus.wmask_b = m;
        end else begin
            bus.read_a = rd; bus.write_a = wr; bus.address_a = a; bus.wdata_a = d; bus.wmask_a = m;
        end
    endtask

    // One complete access; expected rdata is hand-supplied by the caller.
    task automatic access(input logic pb, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d, input logic [1:0] m,
                          input logic [15:0] exp_rd, output int n);
        push_mem(wr, a, d, m);
        push_resp(pb, exp_rd);
        drive_port(pb, rd, wr, a, d, m);
        wait_resp(pb, 30, n);
        drive_port(pb, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        if (pb) last_rd_b = exp_rd; else last_rd_a = exp_rd;
    endtask

    // Memory responder: checks each access against the expected queue every strobe cycle.
    initial begin : responder
        logic     in_acc;
        logic     prev_done;
        logic     have_cur;
        int       cnt;
        mem_exp_t cur;
        logic [15:0] merged;
        in_acc = 1'b0; prev_done = 1'b0; have_cur = 1'b0; cnt = 0;
        cur = '{wr: 1'b0, addr: 16'h0, wdata: 16'h0, mask: 2'b00};
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (prev_done && rst_n) begin
                chk("strobe_clear_after_resp", 32'({bus.mem_read, bus.mem_write}), 32'd0);
            end
            prev_done = 1'b0;
            if (rst_n && (bus.mem_read || bus.mem_write)) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    cnt    = 0;
                    checks++;
                    if (exp_mem.size() == 0) begin
                        failures++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_access: got addr 0x%0h, expected no access", bus.mem_address);
                    end else begin
                        cur      = exp_mem.pop_front();
                        have_cur = 1'b1;
                    end
                end
                cnt++;
                if (have_cur) begin
                    chk("mem_write", 32'(bus.mem_write), 32'(cur.wr));
                    chk("mem_read", 32'(bus.mem_read), 32'(!cur.wr));
                    chk("mem_address", 32'(bus.mem_address), 32'(cur.addr));
                    if (cur.wr) begin
                        chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
                        chk("mem_wmask", 32'(bus.mem_wmask), 32'(cur.mask));
                    end
                end
                if (tie_resp || force_resp || cnt >= latency) begin
                    bus.mem_resp = 1'b1;
                    if (have_cur && cur.wr) begin
                        merged = model_rd(cur.addr);
                        if (cur.mask[0]) merged[7:0]  = cur.wdata[7:0];
                        if (cur.mask[1]) merged[15:8] = cur.wdata[15:8];
                        mem_model[cur.addr] = merged;
                    end else begin
                        bus.mem_rdata = model_rd(bus.mem_address);
                    end
                    prev_done = 1'b1;
                    in_acc    = 1'b0;
                end else begin
                    bus.mem_resp = 1'b0;
                end
            end else begin
                in_acc       = 1'b0;
                bus.mem_resp = tie_resp || force_resp;
            end
        end
    end

    // Response monitor: every resp pulse must match the head of the expected queue.
    initial begin : monitor
        resp_exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.resp_a || bus.resp_b)) begin
                chk("resp_exclusive", 32'(bus.resp_a & bus.resp_b), 32'd0);
                checks++;
                if (exp_resp.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp: got resp_a=%0b resp_b=%0b, expected none",
                             bus.resp_a, bus.resp_b);
                end else begin
                    e = exp_resp.pop_front();
                    if (bus.resp_b !== e.port_b) begin
                        failures++;
                        $display("FAIL resp_port: got resp_b=%0b expected resp_b=%0b", bus.resp_b, e.port_b);
                    end
                    chk("resp_rdata", 32'(e.port_b ? bus.rdata_b : bus.rdata_a), 32'(e.rdata));
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        int seen;
        logic got_a, got_b;

        mem_model[16'h0040] = 16'h1234;
        mem_model[16'h0100] = 16'hAAAA;
        mem_model[16'h0200] = 16'hBBBB;
        mem_model[16'h0300] = 16'hCCCC;
        mem_model[16'h8000] = 16'h0000;

        rst_n = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        drive_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        chk("rst_mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_resp_a", 32'(bus.resp_a), 32'd0);
        chk("rst_resp_b", 32'(bus.resp_b), 32'd0);
        chk("rst_rdata_a", 32'(bus.rdata_a), 32'd0);
        chk("rst_rdata_b", 32'(bus.rdata_b), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single A read, 2-cycle memory: request, 2 strobe cycles, resp.
        latency = 2;
        access(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, 16'h1234, n);
        chk("t1_latency", 32'(n), 32'd3);

        // B read, then masked B write (rdata_b held), then read back merged word.
        latency = 1;
        access(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 2'b00, 16'hBBBB, n);
        @(posedge clk); #1;
        latency = 3;
        access(1'b1, 1'b0, 1'b1, 16'h8000, 16'hBEEF, 2'b01, last_rd_b, n);
        chk("t2_rdata_b_held", 32'(bus.rdata_b), 32'hBBBB);
        @(posedge clk); #1;
        latency = 1;
        access(1'b1, 1'b1, 1'b0, 16'h8000, 16'h0, 2'b00, 16'h00EF, n);
        @(posedge clk); #1;

        // read_b and write_b together: issued as a write.
        access(1'b1, 1'b1, 1'b1, 16'h0010, 16'h5555, 2'b11, last_rd_b, n);
        @(posedge clk); #1;

        // Both ports held: expected grant order B,B,B,B,A,B,B,B,B,A.
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9) begin
                push_mem(1'b0, 16'h0100, 16'h0, 2'b00);
                push_resp(1'b0, 16'hAAAA);
            end else begin
                push_mem(1'b0, 16'h0200, 16'h0, 2'b00);
                push_resp(1'b1, 16'hBBBB);
            end
        end
        drive_port(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0, 2'b00);
        drive_port(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 2'b00);
        seen = 0;
        n    = 0;
        while (seen < 10 && n < 200) begin
            @(posedge clk); #1;
            n++;
            got_a = bus.resp_a;
            got_b = bus.resp_b;
            if (got_a || got_b) seen++;
        end
        if (seen < 10) begin
            checks++;
            failures++;
            $display("FAIL t3_timeout: got %0d resps expected 10", seen);
        end
        drive_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        drive_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        last_rd_a = 16'hAAAA;
        last_rd_b = 16'hBBBB;
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait memory with A held: resp_a every 3 cycles.
        tie_resp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_mem(1'b0, 16'h0100, 16'h0, 2'b00);
            push_resp(1'b0, 16'hAAAA);
        end
        drive_port(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0, 2'b00);
        wait_resp(1'b0, 20, n);
        chk("t6_first_latency", 32'(n), 32'd2);
        for (int k = 0; k < 3; k++) begin
            wait_resp(1'b0, 20, n);
            chk("t6_period", 32'(n), 32'd3);
        end
        drive_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(posedge clk); #1;
        tie_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while BUSY_B with mem_read high: transaction dropped, no resp.
        latency = 100;
        push_mem(1'b0, 16'h0300, 16'h0, 2'b00);
        drive_port(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0, 2'b00);
        n = 0;
        while (!bus.mem_read && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4_strobe_seen", 32'(bus.mem_read), 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        drive_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(posedge clk); #1;
        chk("t4_mem_read_dropped", 32'(bus.mem_read), 32'd0);
        chk("t4_busy_after_rst", 32'(bus.busy), 32'd0);
        chk("t4_no_resp_b", 32'(bus.resp_b), 32'd0);
        chk("t4_rdata_b_cleared", 32'(bus.rdata_b), 32'd0);
        rst_n      = 1'b1;
        force_resp = 1'b1;
        @(posedge clk); #1;
        force_resp = 1'b0;
        chk("t4_late_resp_a", 32'(bus.resp_a), 32'd0);
        chk("t4_late_resp_b", 32'(bus.resp_b), 32'd0);
        chk("t4_late_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("t4_late_resp_b_next", 32'(bus.resp_b), 32'd0);

        // Recovery after reset.
        latency = 1;
        access(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0, 2'b00, 16'hAAAA, n);
        repeat (4) @(posedge clk);
        #1;
        chk("final_resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        chk("final_mem_queue_empty", 32'(exp_mem.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
